// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the two bus masters, the three slaves and bus_arbiter.
// The master modport drives requests and slave readiness; the slave modport is the arbiter side.
interface bus_arbiter_if;
    logic       m1_req;
    logic [1:0] m1_slave_id;
    logic       m2_req;
    logic [1:0] m2_slave_id;
    logic       slave_ready_1;
    logic       slave_ready_2;
    logic       slave_ready_3;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;
    logic       m1_ack;
    logic       m2_ack;
    logic       bus_busy;
    logic       req_err;
    logic       timeout;

    modport master (
        output m1_req, m1_slave_id, m2_req, m2_slave_id,
               slave_ready_1, slave_ready_2, slave_ready_3,
        input  bus_grant, slave_grant, m1_ack, m2_ack, bus_busy, req_err, timeout
    );

    modport slave (
        input  m1_req, m1_slave_id, m2_req, m2_slave_id,
               slave_ready_1, slave_ready_2, slave_ready_3,
        output bus_grant, slave_grant, m1_ack, m2_ack, bus_busy, req_err, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, three-slave round-robin bus arbiter with registered grant/ack outputs.
// Define BUS_ARB_TIMEOUT_EN to build the forced-release counter (TIMEOUT_CYCLES in CONNECT+OWN).
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CONNECT, OWN, RELEASE} state_t;
    typedef enum logic {M1 = 1'b0, M2 = 1'b1} master_t;

    state_t     state;
    master_t    owner;
    master_t    last_master;
    logic [1:0] target;

    logic m1_valid;
    logic m2_valid;
    logic id_err;
    logic grant_m1;
    logic grant_m2;
    logic owner_req;
    logic target_ready;
    logic timeout_hit;

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
        $error("bus_arbiter: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    always_comb begin
        m1_valid     = bus.m1_req && (bus.m1_slave_id != 2'b00);
        m2_valid     = bus.m2_req && (bus.m2_slave_id != 2'b00);
        id_err       = (bus.m1_req && (bus.m1_slave_id == 2'b00)) ||
                       (bus.m2_req && (bus.m2_slave_id == 2'b00));
        // On a tie the master that did not win last time gets the bus.
        grant_m1     = m1_valid && (!m2_valid || (last_master == M2));
        grant_m2     = m2_valid && !grant_m1;
        owner_req    = (owner == M1) ? bus.m1_req : bus.m2_req;
        target_ready = 1'b0;
        case (target)
            2'b01:   target_ready = bus.slave_ready_1;
            2'b10:   target_ready = bus.slave_ready_2;
            2'b11:   target_ready = bus.slave_ready_3;
            default: target_ready = 1'b0;
        endcase
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else if ((state == CONNECT) || (state == OWN)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= M1;
            last_master     <= M2;
            target          <= 2'b00;
            bus.bus_grant   <= 2'b00;
            bus.slave_grant <= 3'b000;
            bus.m1_ack      <= 1'b0;
            bus.m2_ack      <= 1'b0;
            bus.bus_busy    <= 1'b0;
            bus.req_err     <= 1'b0;
            bus.timeout     <= 1'b0;
        end else begin
            bus.req_err <= 1'b0;
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    bus.req_err <= id_err;
                    if (grant_m1) begin
                        state           <= CONNECT;
                        owner           <= M1;
                        last_master     <= M1;
                        target          <= bus.m1_slave_id;
                        bus.bus_grant   <= 2'b01;
                        bus.slave_grant <= {bus.m1_slave_id, 1'b1};
                        bus.bus_busy    <= 1'b1;
                    end else if (grant_m2) begin
                        state           <= CONNECT;
                        owner           <= M2;
                        last_master     <= M2;
                        target          <= bus.m2_slave_id;
                        bus.bus_grant   <= 2'b10;
                        bus.slave_grant <= {bus.m2_slave_id, 1'b1};
                        bus.bus_busy    <= 1'b1;
                    end
                end
                CONNECT, OWN: begin
                    // A voluntary release beats a timeout landing on the same cycle.
                    if (!owner_req || timeout_hit) begin
                        state           <= RELEASE;
                        bus.bus_grant   <= 2'b00;
                        bus.slave_grant <= 3'b000;
                        bus.m1_ack      <= 1'b0;
                        bus.m2_ack      <= 1'b0;
                        bus.timeout     <= owner_req;
                    end else if ((state == CONNECT) && target_ready) begin
                        state      <= OWN;
                        bus.m1_ack <= (owner == M1);
                        bus.m2_ack <= (owner == M2);
                    end
                end
                RELEASE: begin
                    state        <= IDLE;
                    bus.bus_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each stimulus cycle queues the outputs expected in that cycle,
// and a separate monitor pops and compares them on the falling edge.
module tb_bus_arbiter;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam int unsigned TB_CNT_W   = 4;

    // Output vector layout: bus_grant[9:8] slave_grant[7:5] m1_ack m2_ack bus_busy req_err timeout
    localparam logic [9:0] O_ZERO    = 10'b00_000_00_0_0_0;
    localparam logic [9:0] O_REL     = 10'b00_000_00_1_0_0;
    localparam logic [9:0] O_ERR     = 10'b00_000_00_0_1_0;
    localparam logic [9:0] O_REL_TO  = 10'b00_000_00_1_0_1;
    localparam logic [9:0] C1_S1     = 10'b01_011_00_1_0_0;
    localparam logic [9:0] C1_S1_ERR = 10'b01_011_00_1_1_0;
    localparam logic [9:0] O1_S1     = 10'b01_011_10_1_0_0;
    localparam logic [9:0] C1_S2     = 10'b01_101_00_1_0_0;
    localparam logic [9:0] O1_S2     = 10'b01_101_10_1_0_0;
    localparam logic [9:0] C1_S3     = 10'b01_111_00_1_0_0;
    localparam logic [9:0] C2_S3     = 10'b10_111_00_1_0_0;
    localparam logic [9:0] O2_S3     = 10'b10_111_01_1_0_0;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int T4_WAIT = 7;
`else
    localparam int T4_WAIT = 10;
`endif

    typedef struct {
        logic [9:0] outs;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bus_arbiter_if bus ();

    bus_arbiter #(
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic m1r, input logic [1:0] id1,
                                 input logic m2r, input logic [1:0] id2, input logic [2:0] rdy,
                                 input logic [9:0] exp_outs, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        bus.m1_req        = m1r;
        bus.m1_slave_id   = id1;
        bus.m2_req        = m2r;
        bus.m2_slave_id   = id2;
        bus.slave_ready_1 = rdy[0];
        bus.slave_ready_2 = rdy[1];
        bus.slave_ready_3 = rdy[2];
        e.outs = exp_outs;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] act;
        act = {bus.bus_grant, bus.slave_grant, bus.m1_ack, bus.m2_ack,
               bus.bus_busy, bus.req_err, bus.timeout};
        checks++;
        if (act !== e.outs) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", e.name, act, e.outs);
        end
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.m1_req        = 1'b0;
        bus.m1_slave_id   = 2'b00;
        bus.m2_req        = 1'b0;
        bus.m2_slave_id   = 2'b00;
        bus.slave_ready_1 = 1'b0;
        bus.slave_ready_2 = 1'b0;
        bus.slave_ready_3 = 1'b0;

        applyStimulus(1, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "reset");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "reset_idle");

        // Single master, slave 2 ready.
        applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b010, O_ZERO, "t1_req");
        applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b010, C1_S2,  "t1_connect");
        applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b010, O1_S2,  "t1_own");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b010, O1_S2,  "t1_hold");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_REL,  "t1_release");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "t1_idle");

        // Tie after reset: M1 first, then M2 after the release cycle.
        applyStimulus(1, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "t2_reset");
        applyStimulus(0, 1, 2'b01, 1, 2'b11, 3'b111, O_ZERO, "t2_req");
        applyStimulus(0, 1, 2'b01, 1, 2'b11, 3'b111, C1_S1,  "t2_m1_connect");
        applyStimulus(0, 1, 2'b01, 1, 2'b11, 3'b111, O1_S1,  "t2_m1_own");
        applyStimulus(0, 0, 2'b00, 1, 2'b11, 3'b111, O1_S1,  "t2_m1_drop");
        applyStimulus(0, 0, 2'b00, 1, 2'b11, 3'b111, O_REL,  "t2_release");
        applyStimulus(0, 0, 2'b00, 1, 2'b11, 3'b111, O_ZERO, "t2_idle");
        applyStimulus(0, 0, 2'b00, 1, 2'b11, 3'b111, C2_S3,  "t2_m2_connect");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O2_S3,  "t2_m2_own");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_REL,  "t2_m2_release");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "t2_done");

        // Invalid slave id alone, then alongside a valid request.
        applyStimulus(0, 0, 2'b00, 1, 2'b00, 3'b111, O_ZERO,    "t3_bad_id");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O_ERR,     "t3_err_pulse");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O_ZERO,    "t3_err_clear");
        applyStimulus(0, 1, 2'b01, 1, 2'b00, 3'b111, O_ZERO,    "t3_mixed");
        applyStimulus(0, 1, 2'b01, 0, 2'b00, 3'b111, C1_S1_ERR, "t3_m1_connect");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O1_S1,     "t3_m1_own");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_REL,     "t3_release");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO,    "t3_idle");

        // Slave 3 never ready: wait in CONNECT, then abandon; late ready is ignored.
        applyStimulus(0, 1, 2'b11, 0, 2'b00, 3'b011, O_ZERO, "t4_req");
        for (int i = 0; i < T4_WAIT; i++) begin
            applyStimulus(0, 1, 2'b11, 0, 2'b00, 3'b011, C1_S3, "t4_wait_ready");
        end
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, C1_S3,  "t4_drop");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_REL,  "t4_release");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "t4_idle");

        // Reset while owning; afterwards M1 wins the tie even though it won last.
        applyStimulus(0, 1, 2'b01, 0, 2'b00, 3'b111, O_ZERO, "t5_req");
        applyStimulus(0, 1, 2'b01, 0, 2'b00, 3'b111, C1_S1,  "t5_connect");
        applyStimulus(0, 1, 2'b01, 0, 2'b00, 3'b111, O1_S1,  "t5_own");
        applyStimulus(1, 1, 2'b01, 0, 2'b00, 3'b111, O_ZERO, "t5_reset_in_own");
        applyStimulus(0, 1, 2'b01, 1, 2'b10, 3'b111, O_ZERO, "t5_reset_release");
        applyStimulus(0, 1, 2'b01, 1, 2'b10, 3'b111, C1_S1,  "t5_tie_m1");
        applyStimulus(0, 0, 2'b00, 1, 2'b10, 3'b111, O1_S1,  "t5_m1_own");
        applyStimulus(0, 0, 2'b00, 1, 2'b10, 3'b111, O_REL,  "t5_release");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O_ZERO, "t5_idle_no_grant");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "t5_done");

        // Long hold: forced release with the timeout build, unbounded ownership without it.
        applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b111, O_ZERO, "t6_req");
        applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b111, C1_S2,  "t6_connect");
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b111, O1_S2, "t6_own");
        end
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O_REL_TO, "t6_timeout");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO,   "t6_idle");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO,   "t6_done");
`else
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 2'b10, 0, 2'b00, 3'b111, O1_S2, "t6_own_unbounded");
        end
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b111, O1_S2,  "t6_drop");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_REL,  "t6_release");
        applyStimulus(0, 0, 2'b00, 0, 2'b00, 3'b000, O_ZERO, "t6_idle");
`endif

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
